// File: rtl/usb_pkg.sv
// Shared USB endpoint definitions: received PIDs, transmit packet types,
// register-block request codes and the default buffer capacity.
package usb_pkg;

  typedef enum logic [2:0] {
    PID_DATA      = 3'd0,
    PID_IN_TOKEN  = 3'd1,
    PID_OUT_TOKEN = 3'd2,
    PID_ACK       = 3'd3,
    PID_NAK       = 3'd4
  } rx_pid_e;

  typedef enum logic [1:0] {
    TX_NONE = 2'd0,
    TX_DATA = 2'd1,
    TX_ACK  = 2'd2,
    TX_NAK  = 2'd3
  } tx_packet_e;

  localparam logic [7:0] TXC_REQ_DATA = 8'd1;
  localparam logic [7:0] TXC_REQ_NAK  = 8'd3;

  localparam int DEFAULT_MAX_OCCUPANCY = 64;

endpackage

// File: rtl/timeout_counter.sv
// Clear/enable counter that saturates at TERMINAL and flags when it gets there.
module timeout_counter #(
  parameter int TERMINAL = 1023,
  parameter int WIDTH    = 10
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [WIDTH-1:0] count;

  assign terminal = (count == WIDTH'(TERMINAL));

  // Count while enabled; hold at the terminal value instead of wrapping.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/endpoint_txn_controller.sv
// USB endpoint transaction sequencer: decodes tokens, runs the OUT/IN
// handshakes, issues TX requests and reports done/timeout/error strobes.
module endpoint_txn_controller
  import usb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_OCCUPANCY  = DEFAULT_MAX_OCCUPANCY
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [2:0] rx_packet,
  input  logic       rx_packet_done,
  input  logic       rx_error,
  input  logic [7:0] tx_control,
  input  logic [6:0] buffer_occupancy,
  input  logic       tx_transfer_active,
  input  logic       tx_error,
  output logic       tx_start,
  output logic [1:0] tx_packet,
  output logic       d_mode,
  output logic       clear_tx_control,
  output logic       txn_done,
  output logic       txn_timeout,
  output logic       txn_error
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    OUT_WAIT,
    IN_WAIT,
    TX_ISSUE,
    TX_BUSY,
    ACK_WAIT
  } state_e;

  state_e     state, state_next;
  tx_packet_e pkt_q, pkt_next;
  logic       from_in_q, from_in_next;
  logic       seen_rise_q, seen_rise_next;
  logic       done_next, timeout_next, error_next, clear_next;
  logic       restart;
  logic       cnt_terminal, cnt_clear, cnt_enable;

  logic rx_ok, rx_bad, occ_full, occ_empty, risen;

  assign rx_ok     = rx_packet_done && !rx_error;
  assign rx_bad    = rx_packet_done && rx_error;
  assign occ_full  = (buffer_occupancy == 7'(MAX_OCCUPANCY));
  assign occ_empty = (buffer_occupancy == '0);
  // The transfer counts as started once it has been seen high in TX_BUSY.
  assign risen     = seen_rise_q || tx_transfer_active;

  // A token received in OUT_WAIT restarts the wait even when the state is unchanged.
  assign cnt_clear  = (state_next != state) || restart;
  assign cnt_enable = state inside {OUT_WAIT, IN_WAIT, TX_BUSY, ACK_WAIT};

  timeout_counter #(
    .TERMINAL (TIMEOUT_CYCLES - 1),
    .WIDTH    (CNT_W)
  ) u_timeout_counter (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .terminal (cnt_terminal)
  );

  // Next-state and strobe decode; priority is error, then packet event, then timeout.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_next     = state;
    pkt_next       = pkt_q;
    from_in_next   = from_in_q;
    seen_rise_next = 1'b0;
    done_next      = 1'b0;
    timeout_next   = 1'b0;
    error_next     = 1'b0;
    clear_next     = 1'b0;
    restart        = 1'b0;

    case (state)
      IDLE: begin
        if (rx_ok && rx_packet == PID_OUT_TOKEN) begin
          state_next = OUT_WAIT;
        end else if (rx_ok && rx_packet == PID_IN_TOKEN) begin
          state_next = IN_WAIT;
        end
      end

      OUT_WAIT: begin
        if (rx_bad) begin
          error_next = 1'b1;
          state_next = IDLE;
        end else if (rx_ok && rx_packet == PID_DATA) begin
          pkt_next     = occ_full ? TX_NAK : TX_ACK;
          from_in_next = 1'b0;
          state_next   = TX_ISSUE;
        end else if (rx_ok && rx_packet == PID_OUT_TOKEN) begin
          restart = 1'b1;
        end else if (rx_ok && rx_packet == PID_IN_TOKEN) begin
          state_next = IN_WAIT;
        end else if (cnt_terminal) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end
      end

      IN_WAIT: begin
        from_in_next = 1'b1;
        if (tx_control == TXC_REQ_DATA && !occ_empty) begin
          pkt_next   = TX_DATA;
          state_next = TX_ISSUE;
        end else if (tx_control == TXC_REQ_DATA || tx_control == TXC_REQ_NAK) begin
          pkt_next   = TX_NAK;
          state_next = TX_ISSUE;
        end else if (cnt_terminal) begin
          pkt_next     = TX_NAK;
          timeout_next = 1'b1;
          state_next   = TX_ISSUE;
        end
      end

      TX_ISSUE: begin
        state_next = TX_BUSY;
      end

      TX_BUSY: begin
        seen_rise_next = risen;
        if (tx_error) begin
          error_next = 1'b1;
          state_next = IDLE;
        end else if (seen_rise_q && !tx_transfer_active) begin
          if (pkt_q == TX_DATA) begin
            state_next = ACK_WAIT;
          end else begin
            done_next  = 1'b1;
            clear_next = from_in_q;
            state_next = IDLE;
          end
        end else if (!risen && cnt_terminal) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end
      end

      ACK_WAIT: begin
        if (rx_bad) begin
          error_next = 1'b1;
          state_next = IDLE;
        end else if (rx_ok && rx_packet == PID_ACK) begin
          done_next  = 1'b1;
          clear_next = 1'b1;
          state_next = IDLE;
        end else if (rx_ok && rx_packet == PID_NAK) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else if (cnt_terminal) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, latched packet type and registered completion strobes.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!n_rst) begin
      state            <= IDLE;
      pkt_q            <= TX_NONE;
      from_in_q        <= 1'b0;
      seen_rise_q      <= 1'b0;
      txn_done         <= 1'b0;
      txn_timeout      <= 1'b0;
      txn_error        <= 1'b0;
      clear_tx_control <= 1'b0;
    end else begin
      state            <= state_next;
      pkt_q            <= pkt_next;
      from_in_q        <= from_in_next;
      seen_rise_q      <= seen_rise_next;
      txn_done         <= done_next;
      txn_timeout      <= timeout_next;
      txn_error        <= error_next;
      clear_tx_control <= clear_next;
    end
  end

  // TX-side outputs decode only from registered state.
  assign tx_start  = (state == TX_ISSUE);
  assign tx_packet = (state == TX_ISSUE) ? pkt_q : TX_NONE;
  assign d_mode    = (state == TX_ISSUE) || (state == TX_BUSY);

endmodule

// File: tb/tb_endpoint_txn_controller.sv
// Self-checking bench for endpoint_txn_controller: directed handshakes,
// timeout boundaries, error/reset aborts and a randomized transaction loop.
module tb_endpoint_txn_controller;
  import usb_pkg::*;

  localparam int TO     = 16;
  localparam int MAXOCC = 64;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [2:0] rx_packet = 3'd0;
  logic       rx_packet_done = 1'b0;
  logic       rx_error = 1'b0;
  logic [7:0] tx_control = 8'd0;
  logic [6:0] buffer_occupancy = 7'd0;
  logic       tx_transfer_active = 1'b0;
  logic       tx_error = 1'b0;
  logic       tx_start, d_mode, clear_tx_control, txn_done, txn_timeout, txn_error;
  logic [1:0] tx_packet;

  int checks = 0;
  int failures = 0;

  // Observed output vector: {tx_start, tx_packet, d_mode, clear, done, timeout, error}
  logic [7:0] obs;
  assign obs = {tx_start, tx_packet, d_mode, clear_tx_control, txn_done, txn_timeout, txn_error};

  localparam logic [7:0] ZERO = 8'b0;
  localparam logic [7:0] BUSY = 8'b0001_0000;

  always #5 clk = ~clk;

  endpoint_txn_controller #(
    .TIMEOUT_CYCLES (TO),
    .MAX_OCCUPANCY  (MAXOCC)
  ) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .rx_packet          (rx_packet),
    .rx_packet_done     (rx_packet_done),
    .rx_error           (rx_error),
    .tx_control         (tx_control),
    .buffer_occupancy   (buffer_occupancy),
    .tx_transfer_active (tx_transfer_active),
    .tx_error           (tx_error),
    .tx_start           (tx_start),
    .tx_packet          (tx_packet),
    .d_mode             (d_mode),
    .clear_tx_control   (clear_tx_control),
    .txn_done           (txn_done),
    .txn_timeout        (txn_timeout),
    .txn_error          (txn_error)
  );

  // Reference: which packet the endpoint must answer with.
  function automatic logic [1:0] exp_reply(input bit from_in, input int txc, input int occ);
    if (!from_in) return (occ == MAXOCC) ? TX_NAK : TX_ACK;
    if (txc == 1 && occ > 0) return TX_DATA;
    return TX_NAK;
  endfunction

  function automatic logic [7:0] ov(input bit s, input logic [1:0] p, input bit d, input bit c,
                                    input bit dn, input bit t, input bit e);
    return {s, p, d, c, dn, t, e};
  endfunction

  task automatic check(input string tag, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b (start,pkt,dmode,clr,done,tmo,err)", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [7:0] expv);
    tick();
    check(tag, expv);
  endtask

  task automatic quiet(input int n, input string tag, input logic [7:0] expv);
    for (int i = 0; i < n; i++) step(tag, expv);
  endtask

  task automatic rx_step(input logic [2:0] pid, input bit err, input string tag, input logic [7:0] expv);
    rx_packet      = pid;
    rx_packet_done = 1'b1;
    rx_error       = err;
    tick();
    rx_packet_done = 1'b0;
    rx_error       = 1'b0;
    check(tag, expv);
  endtask

  // Issue cycle, busy wait, active burst and fall; the issuing stimulus is already applied.
  task automatic tx_phase(input string tag, input logic [1:0] pkt, input bit tmo_at_issue, input bit clr_after);
    int d;
    int len;
    tick();
    rx_packet_done = 1'b0;
    check({tag, "_issue"}, ov(1, pkt, 1, 0, 0, tmo_at_issue, 0));
    step({tag, "_busy0"}, BUSY);
    d = $urandom_range(0, 3);
    quiet(d, {tag, "_busy_wait"}, BUSY);
    tx_transfer_active = 1'b1;
    len = $urandom_range(1, 6);
    quiet(len, {tag, "_active"}, BUSY);
    tx_transfer_active = 1'b0;
    if (pkt == TX_DATA) step({tag, "_fall"}, ZERO);
    else                step({tag, "_fall"}, ov(0, TX_NONE, 0, clr_after, 1, 0, 0));
  endtask

  task automatic out_txn(input int occ);
    rx_step(PID_OUT_TOKEN, 0, "out_tok", ZERO);
    quiet($urandom_range(0, 4), "out_wait", ZERO);
    buffer_occupancy = 7'(occ);
    rx_packet        = PID_DATA;
    rx_packet_done   = 1'b1;
    tx_phase("out", exp_reply(0, 0, occ), 0, 0);
    step("out_idle", ZERO);
  endtask

  task automatic in_txn(input int txc, input int occ, input bit host_ack);
    logic [7:0] no_req[4];
    logic [1:0] p;
    no_req = '{8'd0, 8'd2, 8'd4, 8'd255};
    rx_step(PID_IN_TOKEN, 0, "in_tok", ZERO);
    for (int i = 0; i < $urandom_range(0, 4); i++) begin
      tx_control = no_req[$urandom_range(0, 3)];
      step("in_no_req", ZERO);
    end
    tx_control       = 8'(txc);
    buffer_occupancy = 7'(occ);
    p = exp_reply(1, txc, occ);
    tx_phase("in", p, 0, p != TX_DATA);
    if (p == TX_DATA) begin
      quiet($urandom_range(0, 4), "ack_wait", ZERO);
      if (host_ack) rx_step(PID_ACK, 0, "host_ack", ov(0, TX_NONE, 0, 1, 1, 0, 0));
      else          rx_step(PID_NAK, 0, "host_nak", ov(0, TX_NONE, 0, 0, 0, 1, 0));
    end
    tx_control = 8'd0;
    step("in_idle", ZERO);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("reset", ZERO);
    n_rst = 1'b1;
    step("post_reset", ZERO);

    // IDLE ignores non-token PIDs, tx_control and errored tokens
    for (int pid = 0; pid < 8; pid++) begin
      if (pid != 1 && pid != 2) rx_step(3'(pid), 0, "idle_ignore_pid", ZERO);
    end
    tx_control = 8'd1;
    buffer_occupancy = 7'd8;
    quiet(3, "idle_ignore_txc", ZERO);
    tx_control = 8'd0;
    rx_step(PID_IN_TOKEN, 1, "idle_tok_err", ZERO);
    tx_control = 8'd1;
    quiet(2, "idle_after_err_tok", ZERO);
    tx_control = 8'd0;

    // Directed handshakes
    out_txn(10);
    in_txn(1, 8, 1);
    in_txn(1, 0, 1);
    in_txn(3, 20, 1);
    out_txn(MAXOCC);
    out_txn(MAXOCC - 1);

    // IN_WAIT timeout produces an automatic NAK
    rx_step(PID_IN_TOKEN, 0, "in_tmo_tok", ZERO);
    quiet(TO - 1, "in_tmo_hold", ZERO);
    tx_phase("in_tmo", TX_NAK, 1, 1);
    step("in_tmo_idle", ZERO);

    // OUT_WAIT timeout boundary
    rx_step(PID_OUT_TOKEN, 0, "out_tmo_tok", ZERO);
    quiet(TO - 1, "out_tmo_hold", ZERO);
    step("out_tmo", ov(0, TX_NONE, 0, 0, 0, 1, 0));
    step("out_tmo_idle", ZERO);

    // DATA on the terminal cycle beats the timeout
    rx_step(PID_OUT_TOKEN, 0, "out_late_tok", ZERO);
    quiet(TO - 1, "out_late_hold", ZERO);
    buffer_occupancy = 7'd5;
    rx_packet = PID_DATA;
    rx_packet_done = 1'b1;
    tx_phase("out_late", TX_ACK, 0, 0);

    // Repeated OUT token restarts the wait window
    rx_step(PID_OUT_TOKEN, 0, "restart_tok1", ZERO);
    quiet(10, "restart_hold1", ZERO);
    rx_step(PID_OUT_TOKEN, 0, "restart_tok2", ZERO);
    quiet(TO - 1, "restart_hold2", ZERO);
    step("restart_tmo", ov(0, TX_NONE, 0, 0, 0, 1, 0));

    // IN token arriving in OUT_WAIT switches to the IN handshake
    rx_step(PID_OUT_TOKEN, 0, "switch_out", ZERO);
    quiet(3, "switch_hold", ZERO);
    rx_step(PID_IN_TOKEN, 0, "switch_in", ZERO);
    tx_control = 8'd1;
    buffer_occupancy = 7'd30;
    tx_phase("switch", TX_DATA, 0, 0);
    rx_step(PID_ACK, 0, "switch_ack", ov(0, TX_NONE, 0, 1, 1, 0, 0));
    tx_control = 8'd0;

    // rx_error on the DATA packet in OUT_WAIT
    rx_step(PID_OUT_TOKEN, 0, "rxerr_tok", ZERO);
    quiet(2, "rxerr_hold", ZERO);
    rx_step(PID_DATA, 1, "out_rxerr", ov(0, TX_NONE, 0, 0, 0, 0, 1));
    step("rxerr_idle", ZERO);

    // Host NAKs DATA: timeout, no clear; next IN resends DATA at once
    rx_step(PID_IN_TOKEN, 0, "retry_tok1", ZERO);
    tx_control = 8'd1;
    buffer_occupancy = 7'd12;
    tx_phase("retry1", TX_DATA, 0, 0);
    quiet(2, "retry_ack_wait", ZERO);
    rx_step(PID_NAK, 0, "retry_nak", ov(0, TX_NONE, 0, 0, 0, 1, 0));
    step("retry_idle", ZERO);
    rx_step(PID_IN_TOKEN, 0, "retry_tok2", ZERO);
    tx_phase("retry2", TX_DATA, 0, 0);
    rx_step(PID_ACK, 0, "retry_ack", ov(0, TX_NONE, 0, 1, 1, 0, 0));
    tx_control = 8'd0;

    // ACK_WAIT timeout boundary
    rx_step(PID_IN_TOKEN, 0, "ackw_tok", ZERO);
    tx_control = 8'd1;
    buffer_occupancy = 7'd40;
    tx_phase("ackw", TX_DATA, 0, 0);
    quiet(TO - 1, "ackw_hold", ZERO);
    step("ackw_tmo", ov(0, TX_NONE, 0, 0, 0, 1, 0));

    // ACK with rx_error in ACK_WAIT
    rx_step(PID_IN_TOKEN, 0, "ackerr_tok", ZERO);
    tx_phase("ackerr", TX_DATA, 0, 0);
    rx_step(PID_ACK, 1, "ackerr", ov(0, TX_NONE, 0, 0, 0, 0, 1));
    tx_control = 8'd0;

    // TX engine never starts
    rx_step(PID_OUT_TOKEN, 0, "norise_tok", ZERO);
    buffer_occupancy = 7'd3;
    rx_packet = PID_DATA;
    rx_packet_done = 1'b1;
    tick();
    rx_packet_done = 1'b0;
    check("norise_issue", ov(1, TX_ACK, 1, 0, 0, 0, 0));
    step("norise_busy0", BUSY);
    quiet(TO - 1, "norise_hold", BUSY);
    step("norise_tmo", ov(0, TX_NONE, 0, 0, 0, 1, 0));

    // tx_error during an IN-sourced transfer: error only, no clear
    rx_step(PID_IN_TOKEN, 0, "txerr_tok", ZERO);
    tx_control = 8'd1;
    buffer_occupancy = 7'd9;
    tick();
    check("txerr_issue", ov(1, TX_DATA, 1, 0, 0, 0, 0));
    tx_transfer_active = 1'b1;
    quiet(3, "txerr_active", BUSY);
    tx_error = 1'b1;
    step("txerr", ov(0, TX_NONE, 0, 0, 0, 0, 1));
    tx_error = 1'b0;
    tx_transfer_active = 1'b0;
    tx_control = 8'd0;
    step("txerr_idle", ZERO);

    // Reset in TX_BUSY
    rx_step(PID_IN_TOKEN, 0, "rst_tok", ZERO);
    tx_control = 8'd1;
    buffer_occupancy = 7'd9;
    tick();
    check("rst_issue", ov(1, TX_DATA, 1, 0, 0, 0, 0));
    tx_transfer_active = 1'b1;
    quiet(2, "rst_active", BUSY);
    n_rst = 1'b0;
    step("rst_busy", ZERO);
    tx_transfer_active = 1'b0;
    tx_control = 8'd0;
    n_rst = 1'b1;
    step("rst_release", ZERO);
    out_txn(7);

    // Randomized transactions against the reference rules
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        out_txn(($urandom_range(0, 3) == 0) ? MAXOCC : int'($urandom_range(0, MAXOCC)));
      end else begin
        in_txn(($urandom_range(0, 2) == 0) ? 3 : 1,
               ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, MAXOCC)),
               1'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
